// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU state, IR opcode and ALU opcode definitions
// Purpose: common types and constants for the control unit and the datapath ALU.
// Ports: none (package).
package cpu_pkg;

  typedef enum logic [2:0] {
    S_RST  = 3'd0,
    S_T0   = 3'd1,
    S_T1   = 3'd2,
    S_T2   = 3'd3,
    S_T3   = 3'd4,
    S_T4   = 3'd5,
    S_T5   = 3'd6,
    S_HALT = 3'd7
  } state_t;

  // Instruction-register opcodes, ir[31:27]
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  // ALU operation codes driven onto the opcode port
  localparam logic [4:0] ALU_NOP = 5'b00000;
  localparam logic [4:0] ALU_ADD = 5'b00001;
  localparam logic [4:0] ALU_SUB = 5'b00010;
  localparam logic [4:0] ALU_AND = 5'b01010;
  localparam logic [4:0] ALU_OR  = 5'b01011;

  typedef enum logic [2:0] {
    IC_ALU     = 3'd0,
    IC_IN      = 3'd1,
    IC_OUT     = 3'd2,
    IC_MFHI    = 3'd3,
    IC_MFLO    = 3'd4,
    IC_NOP     = 3'd5,
    IC_HALT    = 3'd6,
    IC_ILLEGAL = 3'd7
  } iclass_t;

endpackage

// File: rtl/control_unit_instr_decode.sv
// rtl/control_unit_instr_decode.sv - combinational opcode to instruction class and ALU code
// Purpose: classify ir[31:27] and map ALU instructions to their ALU operation code.
// Ports: op (in, 5) opcode field; iclass (out) instruction class; alu_op (out, 5) ALU code.
import cpu_pkg::*;

module instr_decode (
  input  logic [4:0] op,
  output iclass_t    iclass,
  output logic [4:0] alu_op
);

  always_comb begin
    iclass = IC_ILLEGAL;
    alu_op = ALU_NOP;
    case (op)
      OP_ADD:  begin iclass = IC_ALU; alu_op = ALU_ADD; end
      OP_SUB:  begin iclass = IC_ALU; alu_op = ALU_SUB; end
      OP_AND:  begin iclass = IC_ALU; alu_op = ALU_AND; end
      OP_OR:   begin iclass = IC_ALU; alu_op = ALU_OR;  end
      OP_IN:   iclass = IC_IN;
      OP_OUT:  iclass = IC_OUT;
      OP_MFHI: iclass = IC_MFHI;
      OP_MFLO: iclass = IC_MFLO;
      OP_NOP:  iclass = IC_NOP;
      OP_HALT: iclass = IC_HALT;
      default: iclass = IC_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// rtl/control_unit.sv - fetch/decode/execute control FSM for the single-bus CPU
// Purpose: sequences fetch (T0-T2), decode (T3) and execute (T3-T5) strobes.
// Ports: clk, clr (sync active-high reset), ir (32-bit IR), stop (fetch hold);
//        read/write memory strobes; *out bus-source selects; *in load enables;
//        Gra/Grb/Grc/Rin/Rout/incPC register-file controls; opcode (5-bit ALU op);
//        run (low in HALT); illegal (T3 pulse on undefined opcode).
import cpu_pkg::*;

module control_unit #(
  parameter bit ILLEGAL_AS_NOP = 1'b1
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] ir,
  input  logic        stop,
  output logic        read,
  output logic        write,
  output logic        PCout,
  output logic        MDRout,
  output logic        ZLowOut,
  output logic        ZHighOut,
  output logic        HIout,
  output logic        LOout,
  output logic        InPortOut,
  output logic        Cout,
  output logic        BAout,
  output logic        MARin,
  output logic        MDRin,
  output logic        PCin,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        HIin,
  output logic        LOin,
  output logic        OutPortIn,
  output logic        InPortIn,
  output logic        CONN_in,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        incPC,
  output logic [4:0]  opcode,
  output logic        run,
  output logic        illegal
);

  state_t     state_q, state_d;
  iclass_t    iclass;
  logic [4:0] alu_op;
  logic       unused_ir;

  // Only the opcode field steers control; operand fields go to the register-file select logic.
  assign unused_ir = ^ir[26:0];

  instr_decode u_decode (
    .op     (ir[31:27]),
    .iclass (iclass),
    .alu_op (alu_op)
  );

  always_ff @(posedge clk) begin
    if (clr) state_q <= S_RST;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RST:  state_d = S_T0;
      S_T0:   state_d = stop ? S_T0 : S_T1;
      S_T1:   state_d = S_T2;
      S_T2:   state_d = S_T3;
      S_T3: begin
        case (iclass)
          IC_ALU:     state_d = S_T4;
          IC_HALT:    state_d = S_HALT;
          IC_ILLEGAL: state_d = ILLEGAL_AS_NOP ? S_T0 : S_HALT;
          default:    state_d = S_T0;
        endcase
      end
      S_T4:   state_d = S_T5;
      S_T5:   state_d = S_T0;
      S_HALT: state_d = S_HALT;
      default: state_d = S_RST;
    endcase
  end

  always_comb begin
    read      = 1'b0;
    write     = 1'b0;
    PCout     = 1'b0;
    MDRout    = 1'b0;
    ZLowOut   = 1'b0;
    ZHighOut  = 1'b0;
    HIout     = 1'b0;
    LOout     = 1'b0;
    InPortOut = 1'b0;
    Cout      = 1'b0;
    BAout     = 1'b0;
    MARin     = 1'b0;
    MDRin     = 1'b0;
    PCin      = 1'b0;
    IRin      = 1'b0;
    Yin       = 1'b0;
    Zin       = 1'b0;
    HIin      = 1'b0;
    LOin      = 1'b0;
    OutPortIn = 1'b0;
    InPortIn  = 1'b0;
    CONN_in   = 1'b0;
    Gra       = 1'b0;
    Grb       = 1'b0;
    Grc       = 1'b0;
    Rin       = 1'b0;
    Rout      = 1'b0;
    incPC     = 1'b0;
    opcode    = ALU_NOP;
    run       = (state_q != S_HALT);
    illegal   = 1'b0;
    case (state_q)
      S_T0: begin
        // A held fetch must not bump the PC or latch MAR/Z, so stop qualifies the strobes.
        if (!stop) begin
          PCout = 1'b1;
          MARin = 1'b1;
          incPC = 1'b1;
          Zin   = 1'b1;
        end
      end
      S_T1: begin
        ZLowOut = 1'b1;
        PCin    = 1'b1;
        read    = 1'b1;
        MDRin   = 1'b1;
      end
      S_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      S_T3: begin
        case (iclass)
          IC_ALU:  begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
          IC_IN:   begin InPortOut = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          IC_OUT:  begin Gra = 1'b1; Rout = 1'b1; OutPortIn = 1'b1; end
          IC_MFHI: begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          IC_MFLO: begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          IC_ILLEGAL: illegal = 1'b1;
          default: ;
        endcase
      end
      S_T4: begin
        // T4/T5 are only reachable through an ALU instruction in T3.
        Grc    = 1'b1;
        Rout   = 1'b1;
        Zin    = 1'b1;
        opcode = alu_op;
      end
      S_T5: begin
        ZLowOut = 1'b1;
        Gra     = 1'b1;
        Rin     = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - directed self-checking bench for control_unit
module tb_control_unit;

  logic        clk = 1'b0;
  logic        clr;
  logic [31:0] ir;
  logic        stop;
  logic read, write, PCout, MDRout, ZLowOut, ZHighOut, HIout, LOout, InPortOut, Cout, BAout;
  logic MARin, MDRin, PCin, IRin, Yin, Zin, HIin, LOin, OutPortIn, InPortIn, CONN_in;
  logic Gra, Grb, Grc, Rin, Rout, incPC, run, illegal;
  logic [4:0] opcode;
  logic [28:0] obs;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  control_unit #(.ILLEGAL_AS_NOP(1'b1)) dut (
    .clk(clk), .clr(clr), .ir(ir), .stop(stop),
    .read(read), .write(write), .PCout(PCout), .MDRout(MDRout), .ZLowOut(ZLowOut),
    .ZHighOut(ZHighOut), .HIout(HIout), .LOout(LOout), .InPortOut(InPortOut), .Cout(Cout),
    .BAout(BAout), .MARin(MARin), .MDRin(MDRin), .PCin(PCin), .IRin(IRin), .Yin(Yin),
    .Zin(Zin), .HIin(HIin), .LOin(LOin), .OutPortIn(OutPortIn), .InPortIn(InPortIn),
    .CONN_in(CONN_in), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
    .incPC(incPC), .opcode(opcode), .run(run), .illegal(illegal)
  );

  assign obs = {read, write, PCout, MDRout, ZLowOut, ZHighOut, HIout, LOout, InPortOut,
                Cout, BAout, MARin, MDRin, PCin, IRin, Yin, Zin, HIin, LOin, OutPortIn,
                InPortIn, CONN_in, Gra, Grb, Grc, Rin, Rout, incPC, illegal};

  localparam logic [28:0] B_READ = 29'd1 << 28, B_PCOUT = 29'd1 << 26, B_MDROUT = 29'd1 << 25;
  localparam logic [28:0] B_ZLOW = 29'd1 << 24, B_HIOUT = 29'd1 << 22, B_LOOUT = 29'd1 << 21;
  localparam logic [28:0] B_INPO = 29'd1 << 20, B_MARIN = 29'd1 << 17, B_MDRIN = 29'd1 << 16;
  localparam logic [28:0] B_PCIN = 29'd1 << 15, B_IRIN = 29'd1 << 14, B_YIN = 29'd1 << 13;
  localparam logic [28:0] B_ZIN = 29'd1 << 12, B_OPIN = 29'd1 << 9, B_GRA = 29'd1 << 6;
  localparam logic [28:0] B_GRB = 29'd1 << 5, B_GRC = 29'd1 << 4, B_RIN = 29'd1 << 3;
  localparam logic [28:0] B_ROUT = 29'd1 << 2, B_INCPC = 29'd1 << 1, B_ILL = 29'd1;

  localparam logic [28:0] E_NONE = 29'd0;
  localparam logic [28:0] E_T0   = B_PCOUT | B_MARIN | B_INCPC | B_ZIN;
  localparam logic [28:0] E_T1   = B_ZLOW | B_PCIN | B_READ | B_MDRIN;
  localparam logic [28:0] E_T2   = B_MDROUT | B_IRIN;
  localparam logic [28:0] E_T3A  = B_GRB | B_ROUT | B_YIN;
  localparam logic [28:0] E_T4A  = B_GRC | B_ROUT | B_ZIN;
  localparam logic [28:0] E_T5A  = B_ZLOW | B_GRA | B_RIN;
  localparam logic [28:0] E_OUT  = B_GRA | B_ROUT | B_OPIN;
  localparam logic [28:0] E_IN   = B_INPO | B_GRA | B_RIN;
  localparam logic [28:0] E_MFHI = B_HIOUT | B_GRA | B_RIN;
  localparam logic [28:0] E_MFLO = B_LOOUT | B_GRA | B_RIN;

  // Opcode of an undefined instruction, used as junk ir while fetching.
  localparam logic [31:0] IR_JUNK = 32'hF8000000;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clr = 1'b1; stop = 1'b0; ir = IR_JUNK;
    tick();
    #2;
    checks++;
    if (obs !== E_NONE || opcode !== 5'd0) begin
      errors++;
      $display("FAIL reset_hold1: obs=%h op=%b, want obs=%h op=00000", obs, opcode, E_NONE);
    end
    tick();
    clr = 1'b0;
    #2;
    checks++;
    if (obs !== E_NONE || opcode !== 5'd0) begin
      errors++;
      $display("FAIL reset_hold2: obs=%h op=%b, want obs=%h op=00000", obs, opcode, E_NONE);
    end
    tick();
    #2;
    checks++;
    if (obs !== E_T0 || run !== 1'b1) begin
      errors++;
      $display("FAIL reset_first_t0: obs=%h run=%b, want obs=%h run=1", obs, run, E_T0);
    end
  endtask

  task automatic test_out();
    logic [28:0] e [5];
    e = '{E_T0, E_T1, E_T2, E_OUT, E_T0};
    for (int c = 0; c < 5; c++) begin
      ir = (c < 3) ? IR_JUNK : 32'hB9000000;
      stop = 1'b0;
      #2;
      checks++;
      if (obs !== e[c] || opcode !== 5'd0 || run !== 1'b1) begin
        errors++;
        $display("FAIL out_cycle%0d: obs=%h op=%b run=%b, want obs=%h op=00000 run=1",
                 c, obs, opcode, run, e[c]);
      end
      if (c < 4) tick();
    end
  endtask

  task automatic test_add();
    logic [28:0] e [7];
    logic [4:0]  eop [7];
    e   = '{E_T0, E_T1, E_T2, E_T3A, E_T4A, E_T5A, E_T0};
    eop = '{5'd0, 5'd0, 5'd0, 5'd0, 5'b00001, 5'd0, 5'd0};
    for (int c = 0; c < 7; c++) begin
      ir = (c < 3) ? IR_JUNK : 32'h18918000;
      stop = 1'b0;
      #2;
      checks++;
      if (obs !== e[c] || opcode !== eop[c] || run !== 1'b1) begin
        errors++;
        $display("FAIL add_cycle%0d: obs=%h op=%b run=%b, want obs=%h op=%b run=1",
                 c, obs, opcode, run, e[c], eop[c]);
      end
      if (c < 6) tick();
    end
  endtask

  task automatic test_misc();
    logic [31:0] irs [4];
    logic [28:0] t3 [4];
    logic [28:0] e;
    irs = '{32'hB0800000, 32'hC1000000, 32'hC9800000, 32'hD0000000};
    t3  = '{E_IN, E_MFHI, E_MFLO, E_NONE};
    for (int i = 0; i < 4; i++) begin
      for (int c = 0; c < 5; c++) begin
        ir = (c < 3) ? IR_JUNK : irs[i];
        stop = 1'b0;
        case (c)
          0, 4:    e = E_T0;
          1:       e = E_T1;
          2:       e = E_T2;
          default: e = t3[i];
        endcase
        #2;
        checks++;
        if (obs !== e || opcode !== 5'd0) begin
          errors++;
          $display("FAIL misc%0d_cycle%0d: obs=%h op=%b, want obs=%h op=00000",
                   i, c, obs, opcode, e);
        end
        if (c < 4) tick();
      end
    end
  endtask

  task automatic test_sub_clr();
    logic [28:0] e [5];
    logic [4:0]  eop [5];
    e   = '{E_T0, E_T1, E_T2, E_T3A, E_T4A};
    eop = '{5'd0, 5'd0, 5'd0, 5'd0, 5'b00010};
    for (int c = 0; c < 5; c++) begin
      ir = (c < 3) ? IR_JUNK : 32'h20000000;
      stop = 1'b0;
      clr = (c == 4);
      #2;
      checks++;
      if (obs !== e[c] || opcode !== eop[c]) begin
        errors++;
        $display("FAIL sub_cycle%0d: obs=%h op=%b, want obs=%h op=%b", c, obs, opcode, e[c], eop[c]);
      end
      tick();
    end
    clr = 1'b0;
    #2;
    checks++;
    if (obs !== E_NONE || opcode !== 5'd0) begin
      errors++;
      $display("FAIL sub_clr_rst: obs=%h op=%b, want obs=%h op=00000", obs, opcode, E_NONE);
    end
    tick();
    #2;
    checks++;
    if (obs !== E_T0) begin
      errors++;
      $display("FAIL sub_clr_t0: obs=%h, want obs=%h", obs, E_T0);
    end
  endtask

  task automatic test_halt();
    logic [28:0] e;
    logic        erun;
    for (int c = 0; c < 14; c++) begin
      ir = (c < 3) ? IR_JUNK : ((c == 3) ? 32'hD8000000 : 32'h18918000 ^ c);
      stop = (c > 3) ? c[0] : 1'b0;
      case (c)
        0:       e = E_T0;
        1:       e = E_T1;
        2:       e = E_T2;
        default: e = E_NONE;
      endcase
      erun = (c < 4);
      #2;
      checks++;
      if (obs !== e || opcode !== 5'd0 || run !== erun) begin
        errors++;
        $display("FAIL halt_cycle%0d: obs=%h op=%b run=%b, want obs=%h op=00000 run=%b",
                 c, obs, opcode, run, e, erun);
      end
      tick();
    end
    stop = 1'b0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    #2;
    checks++;
    if (obs !== E_NONE || opcode !== 5'd0) begin
      errors++;
      $display("FAIL halt_clr_rst: obs=%h op=%b, want obs=%h op=00000", obs, opcode, E_NONE);
    end
    tick();
    #2;
    checks++;
    if (obs !== E_T0 || run !== 1'b1) begin
      errors++;
      $display("FAIL halt_clr_t0: obs=%h run=%b, want obs=%h run=1", obs, run, E_T0);
    end
  endtask

  task automatic test_illegal_stop();
    logic [28:0] e [5];
    e = '{E_T0, E_T1, E_T2, B_ILL, E_T0};
    for (int c = 0; c < 5; c++) begin
      ir = (c < 3) ? 32'hB9000000 : 32'hF8000000;
      stop = 1'b0;
      #2;
      checks++;
      if (obs !== e[c] || run !== 1'b1) begin
        errors++;
        $display("FAIL illegal_cycle%0d: obs=%h run=%b, want obs=%h run=1", c, obs, run, e[c]);
      end
      if (c < 4) tick();
    end
    for (int k = 0; k < 5; k++) begin
      stop = 1'b1;
      #2;
      checks++;
      if (obs !== E_NONE || opcode !== 5'd0) begin
        errors++;
        $display("FAIL stop_hold%0d: obs=%h op=%b, want obs=%h op=00000", k, obs, opcode, E_NONE);
      end
      tick();
    end
    stop = 1'b0;
    #2;
    checks++;
    if (obs !== E_T0) begin
      errors++;
      $display("FAIL stop_release_t0: obs=%h, want obs=%h", obs, E_T0);
    end
    tick();
    #2;
    checks++;
    if (obs !== E_T1) begin
      errors++;
      $display("FAIL stop_release_t1: obs=%h, want obs=%h", obs, E_T1);
    end
  endtask

  initial begin
    clr = 1'b1;
    stop = 1'b0;
    ir = IR_JUNK;
    test_reset();
    test_out();
    test_add();
    test_misc();
    test_sub_clr();
    test_halt();
    test_illegal_stop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have parameter ILLEGAL_AS_NOP, default 1, meaning an undefined opcode returns to fetch instead of halting.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 SHALL have port clr, input, 1 bit: reset, synchronous, active-high.
REQ-004 SHALL have port ir, input, 32 bits: instruction register contents; opcode is ir[31:27].
REQ-005 SHALL have port stop, input, 1 bit: sampled only in T0; when high, the fetch is held.
REQ-006 SHALL have ports read and write, outputs, 1 bit each: memory strobes.
REQ-007 SHALL have ports PCout, MDRout, ZLowOut, ZHighOut, HIout, LOout, InPortOut, Cout and BAout, outputs, 1 bit each: bus-source selects, at most one high per cycle.
REQ-008 SHALL have ports MARin, MDRin, PCin, IRin, Yin, Zin, HIin, LOin, OutPortIn, InPortIn and CONN_in, outputs, 1 bit each: register load enables.
REQ-009 SHALL have ports Gra, Grb, Grc, Rin, Rout and incPC, outputs, 1 bit each: register-file select/enable and PC increment.
REQ-010 SHALL have port opcode, output, 5 bits: ALU operation code.
REQ-011 SHALL have port run, output, 1 bit: high unless in HALT.
REQ-012 SHALL have port illegal, output, 1 bit: one-cycle pulse in T3 for an undefined opcode.

Function
REQ-013 SHALL be a Moore FSM, one state per clk; every output SHALL be decoded from the registered state plus ir[31:27] only.
REQ-014 SHALL have the states RST, T0, T1, T2, T3, T4, T5 and HALT.
REQ-015 SHALL drive every output not named in a state to 0; opcode SHALL default to nop (00000).
REQ-016 In RST, all outputs SHALL be 0 and the next state SHALL be T0.
REQ-017 In T0, SHALL drive PCout, MARin, incPC and Zin; if stop=1, SHALL stay in T0 with all outputs 0.
REQ-018 In T1, SHALL drive ZLowOut, PCin, read and MDRin.
REQ-019 In T2, SHALL drive MDRout and IRin; the next state SHALL be T3.
REQ-020 Decoding SHALL occur in T3 from the ir value loaded at the end of T2.
REQ-021 add(00011), sub(00100), and(00101), or(00110): T3 SHALL drive Grb, Rout and Yin.
REQ-022 For those ALU ops, T4 SHALL drive Grc, Rout, Zin and opcode=ALU code (add 00001, sub 00010, and 01010, or 01011).
REQ-023 For those ALU ops, T5 SHALL drive ZLowOut, Gra and Rin, then return to T0.
REQ-024 in(10110): T3 SHALL drive InPortOut, Gra and Rin, then go to T0.
REQ-025 out(10111): T3 SHALL drive Gra, Rout and OutPortIn, then go to T0.
REQ-026 mfhi(11000) and mflo(11001): T3 SHALL drive HIout or LOout respectively, plus Gra and Rin, then go to T0.
REQ-027 nop(11010): T3 SHALL drive no strobes, then go to T0.
REQ-028 halt(11011): T3 SHALL go to HALT; HALT SHALL hold with run=0 and all other outputs 0 until clr.
REQ-029 Undefined opcode: SHALL pulse illegal in T3, then go to T0 if ILLEGAL_AS_NOP=1, else to HALT.
REQ-030 Instruction latency SHALL be 4 cycles for in, out, mfhi, mflo and nop, and 6 cycles for ALU ops.
REQ-031 Rin and Rout SHALL never be high in the same cycle.
REQ-032 ir changes outside T3 through T5 SHALL have no effect on outputs.

Reset
REQ-033 clr=1 at a clock edge SHALL force state RST in any state, including mid-instruction and HALT, with all outputs 0 on the following cycle.
REQ-034 clr SHALL take priority over stop and over decode.
REQ-035 The first T0 SHALL occur exactly one cycle after clr deasserts.

Structure
REQ-036 A shared package cpu_pkg SHALL hold the state enum, the IR opcode constants and the ALU opcode constants, which the datapath ALU also uses.
REQ-037 A single sub-module, instr_decode (combinational, ir[31:27] -> instruction class plus ALU code), SHALL be instantiated; the FSM SHALL remain in control_unit.

Verification
REQ-038 clr 2 cycles, then release with stop=0 -> RST, then T0 with PCout=MARin=incPC=Zin=1 exactly one cycle after release.
REQ-039 ir=B9000000 (out R2) -> T3 has Gra=Rout=OutPortIn=1 only; next cycle is T0; latency 4 cycles.
REQ-040 ir=add R1,R2,R3 -> T3 Grb/Rout/Yin; T4 Grc/Rout/Zin with opcode=00001; T5 ZLowOut/Gra/Rin; back to T0.
REQ-041 ir=halt -> HALT with run=0 held 10 cycles; clr pulse -> RST, then T0 with run=1.
REQ-042 clr asserted during T4 of sub -> next cycle RST with all outputs 0; no Zin/Rin strobe leaks.
REQ-043 ir opcode 11111 with ILLEGAL_AS_NOP=1 -> illegal=1 for exactly one T3 cycle, then T0; stop=1 in T0 holds T0 with outputs 0 for 5 cycles.
